alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Sequential successor to the combinational ALU-control decoder: accepts RV32 OP/OP-IMM `funct3`/`funct7` fields through a valid/ready handshake and decodes them into the ALU `select`/`control` code. It also handles the execute-stage timing of multi-cycle M-extension operations and flags illegal encodings. It sits between decode and the execute datapath. It stalls decode while a multiply or divide is in flight and holds its result code until execute consumes it.

## Interface
- `MUL_LATENCY`, default 3: cycles from accept to `out_valid` for `mul*`. Legal range is 1..255.
- `DIV_LATENCY`, default 33: cycles from accept to `out_valid` for `div*`/`rem*`. Legal range is 1..255.
- `ENABLE_M`, default 1: when 0, every M-extension encoding is illegal.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort. Returns the block to IDLE.
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: the block can accept this cycle.
- `in_is_imm` in 1: 1 = OP-IMM, 0 = OP (register-register).
- `funct3` in 3: instruction `funct3`.
- `funct7` in 7: instruction `funct7`. For OP-IMM this is `imm[11:5]`.
- `out_valid` out 1: the code on `select`/`control`/`illegal` is valid.
- `out_ready` in 1: execute consumes the code.
- `select` out 3: functional-unit select.
- `control` out 2: unit sub-operation.
- `illegal` out 1: the encoding is not supported.
- `busy` out 1: high when state ≠ IDLE.

## Operation
Decode for OP (`in_is_imm` = 0):
- `add` = 000/00, `sub` = 000/01, `slt` = 000/10, `sltu` = 000/11.
- `mul`/`mulh`/`mulhsu`/`mulhu` = 001 with `control` = `funct3[1:0]`.
- `div`/`divu`/`rem`/`remu` = 010 with `control` = `funct3[1:0]`.
- `sll` = 011/00.
- `srl` = 100/00, `sra` = 100/01.
- `xor` = 101/00, `or` = 110/00, `and` = 111/00.

Decode for OP-IMM (`in_is_imm` = 1):
- `funct7` is ignored except for shifts. `funct3` 000 is always `addi` (000/00); there is no subtract.
- `slli` requires `funct7` = 0000000.
- `srli` requires `funct7` = 0000000; `srai` requires `funct7` = 0100000.
- M encodings do not exist in this mode.

Illegal encodings:
- Any other combination, and M ops when `ENABLE_M` = 0, decode to 000/00 with `illegal` = 1.
- Illegal instructions take the single-cycle path.

States:
- IDLE: `in_ready` = 1. On accept:
  - single-cycle class goes to HOLD;
  - mul class goes to WAIT with the counter loaded to `MUL_LATENCY`−1;
  - div class goes to WAIT with the counter loaded to `DIV_LATENCY`−1;
  - a latency of 1 goes straight to HOLD.
- WAIT: `in_ready` = 0. The counter decrements each cycle. When it reaches 1, the next edge enters HOLD.
- HOLD: `out_valid` = 1.
  - If `out_ready` = 1, `in_ready` = 1: the output drains and a new accept may occur in the same cycle (back-to-back).
  - Drain without accept goes to IDLE. Drain with accept follows the IDLE accept rules.
  - If `out_ready` = 0, stay in HOLD with the outputs frozen.

Output and boundary rules:
- `select`, `control` and `illegal` are registered at accept and remain stable until the next accept.
- `flush` has priority over everything: next state is IDLE and `out_valid` drops. Any `in_valid` in the flush cycle is not accepted (`in_ready` is forced to 0 while `flush` = 1).
- Reset mid-WAIT or mid-HOLD abandons the operation immediately. No output is produced.

## Timing
- Reset values: IDLE, `out_valid` 0, `in_ready` 1, `select` 000, `control` 00, `illegal` 0, `busy` 0.
- Accept occurs at edge N, defined as `in_valid` && `in_ready` at edge N.
- Single-cycle op: `out_valid` is high from cycle N+1.
- mul: `out_valid` is high from cycle N+`MUL_LATENCY`.
- div: `out_valid` is high from cycle N+`DIV_LATENCY`.
- Throughput: one single-cycle op per clock while `out_ready` = 1.
- The latency counter is 8 bits. There is no combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` and `flush` only.

## Structure
- `alu_pkg` holds:
  - `select` localparams: `SEL_ADD`, `SEL_MUL`, `SEL_DIV`, `SEL_SLL`, `SEL_SR`, `SEL_XOR`, `SEL_OR`, `SEL_AND`;
  - `control` localparams;
  - an op-class enum: SINGLE, MUL, DIV;
  - the FSM state enum.
- The combinational sub-module `alu_op_decode` (inputs `funct3`, `funct7`, `in_is_imm`, `ENABLE_M`; outputs `select`, `control`, `illegal`, class) is instantiated once. The FSM, counter and output registers live in `alu_dispatch`.

## Test plan
- Reset then `sub` (OP, 000/0100000), `out_ready` = 1 → `out_valid` at N+1, `select` 000, `control` 01, then `busy` 0.
- `mulhu` (011/0000001), `MUL_LATENCY` = 3 → `in_ready` 0 for 2 cycles, `out_valid` at N+3 with 001/11.
- `div` with `DIV_LATENCY` = 33 and `out_ready` low for 5 cycles after valid → outputs frozen; an `and` presented during the stall is accepted on the drain cycle and is valid next cycle.
- OP-IMM `srai` (101/0100000) → 100/01; OP-IMM 000/0100000 → `addi` 000/00; OP-IMM 101/0000001 → `illegal` 1; `ENABLE_M` = 0 with `mul` → `illegal` 1, single-cycle.
- `flush` on WAIT cycle 10 of a `div` → IDLE next cycle, no `out_valid`; `flush` with a simultaneous `in_valid` → no accept.
- `rst` asserted asynchronously mid-WAIT → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU dispatch block: unit select/control codes,
// operation classes and dispatch FSM states.
package alu_pkg;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_MUL = 3'd1;
  localparam logic [2:0] SEL_DIV = 3'd2;
  localparam logic [2:0] SEL_SLL = 3'd3;
  localparam logic [2:0] SEL_SR  = 3'd4;
  localparam logic [2:0] SEL_XOR = 3'd5;
  localparam logic [2:0] SEL_OR  = 3'd6;
  localparam logic [2:0] SEL_AND = 3'd7;

  localparam logic [1:0] CTL_NONE = 2'd0;
  localparam logic [1:0] CTL_ADD  = 2'd0;
  localparam logic [1:0] CTL_SUB  = 2'd1;
  localparam logic [1:0] CTL_SLT  = 2'd2;
  localparam logic [1:0] CTL_SLTU = 2'd3;
  localparam logic [1:0] CTL_SRL  = 2'd0;
  localparam logic [1:0] CTL_SRA  = 2'd1;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MUL    = 2'd1,
    CLS_DIV    = 2'd2
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_dispatch_if.sv
// Decode-side and execute-side handshake bundle of the ALU dispatch block.
interface alu_dispatch_if;
  import alu_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       in_is_imm;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] select;
  logic [1:0] control;
  logic       illegal;

  modport master (
    output in_valid, in_is_imm, funct3, funct7, out_ready,
    input  in_ready, out_valid, select, control, illegal
  );

  modport slave (
    input  in_valid, in_is_imm, funct3, funct7, out_ready,
    output in_ready, out_valid, select, control, illegal
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32 OP/OP-IMM funct3/funct7 decoder producing the ALU
// select/control code, the illegal flag and the timing class.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic       in_is_imm,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] select,
  output logic [1:0] control,
  output logic       illegal,
  output op_class_e  op_class
);

  logic f7_base_s;
  logic f7_alt_s;
  logic f7_mext_s;

  assign f7_base_s = (funct7 == F7_BASE);
  assign f7_alt_s  = (funct7 == F7_ALT);
  assign f7_mext_s = (funct7 == F7_MEXT);

  // Illegal encodings keep the 000/00 defaults and only raise the flag.
  always_comb begin
    select   = SEL_ADD;
    control  = CTL_NONE;
    illegal  = 1'b0;
    op_class = CLS_SINGLE;
    if (in_is_imm) begin
      case (funct3)
        3'b000: begin select = SEL_ADD; control = CTL_ADD;  end
        3'b010: begin select = SEL_ADD; control = CTL_SLT;  end
        3'b011: begin select = SEL_ADD; control = CTL_SLTU; end
        3'b100: select = SEL_XOR;
        3'b110: select = SEL_OR;
        3'b111: select = SEL_AND;
        3'b001: begin
          if (f7_base_s) begin
            select = SEL_SLL;
          end else begin
            illegal = 1'b1;
          end
        end
        3'b101: begin
          if (f7_base_s) begin
            select  = SEL_SR;
            control = CTL_SRL;
          end else if (f7_alt_s) begin
            select  = SEL_SR;
            control = CTL_SRA;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end else if (f7_mext_s) begin
      if (ENABLE_M) begin
        select   = funct3[2] ? SEL_DIV : SEL_MUL;
        control  = funct3[1:0];
        op_class = funct3[2] ? CLS_DIV : CLS_MUL;
      end else begin
        illegal = 1'b1;
      end
    end else if (f7_alt_s) begin
      case (funct3)
        3'b000: begin select = SEL_ADD; control = CTL_SUB; end
        3'b101: begin select = SEL_SR;  control = CTL_SRA; end
        default: illegal = 1'b1;
      endcase
    end else if (f7_base_s) begin
      case (funct3)
        3'b000: begin select = SEL_ADD; control = CTL_ADD;  end
        3'b001: select = SEL_SLL;
        3'b010: begin select = SEL_ADD; control = CTL_SLT;  end
        3'b011: begin select = SEL_ADD; control = CTL_SLTU; end
        3'b100: select = SEL_XOR;
        3'b101: begin select = SEL_SR;  control = CTL_SRL;  end
        3'b110: select = SEL_OR;
        3'b111: select = SEL_AND;
        default: illegal = 1'b1;
      endcase
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// ALU dispatch: accepts decoded funct fields, models multi-cycle mul/div
// latency and holds the registered select/control code until consumed.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33,
  parameter bit ENABLE_M    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_dispatch_if.slave     bus,
  output logic              busy
);

  localparam logic [7:0] MUL_CNT = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LATENCY - 1);

  state_e     state_r;
  state_e     state_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic [2:0] select_r;
  logic [1:0] control_r;
  logic       illegal_r;

  logic [2:0] dec_select_s;
  logic [1:0] dec_control_s;
  logic       dec_illegal_s;
  op_class_e  dec_class_s;

  state_e     tgt_state_s;
  logic [7:0] tgt_cnt_s;
  logic       in_ready_s;
  logic       accept_s;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .in_is_imm (bus.in_is_imm),
    .funct3    (bus.funct3),
    .funct7    (bus.funct7),
    .select    (dec_select_s),
    .control   (dec_control_s),
    .illegal   (dec_illegal_s),
    .op_class  (dec_class_s)
  );

  // in_ready depends only on registered state, out_ready and flush.
  assign in_ready_s = !flush &&
                      ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && bus.out_ready));
  assign accept_s   = bus.in_valid && in_ready_s;

  // Where an accepted op lands; a latency of 1 skips WAIT entirely.
  always_comb begin
    tgt_state_s = ST_HOLD;
    tgt_cnt_s   = 8'd0;
    case (dec_class_s)
      CLS_MUL: begin
        tgt_state_s = (MUL_CNT == 8'd0) ? ST_HOLD : ST_WAIT;
        tgt_cnt_s   = MUL_CNT;
      end
      CLS_DIV: begin
        tgt_state_s = (DIV_CNT == 8'd0) ? ST_HOLD : ST_WAIT;
        tgt_cnt_s   = DIV_CNT;
      end
      default: begin
        tgt_state_s = ST_HOLD;
        tgt_cnt_s   = 8'd0;
      end
    endcase
  end

  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_s = tgt_state_s;
            cnt_s   = tgt_cnt_s;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_s = cnt_r - 8'd1;
          if (cnt_r <= 8'd1) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!bus.out_ready) begin
            state_s = ST_HOLD;
          end else if (accept_s) begin
            state_s = tgt_state_s;
            cnt_s   = tgt_cnt_s;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Result code is captured at accept and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select_r  <= SEL_ADD;
      control_r <= CTL_NONE;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      select_r  <= dec_select_s;
      control_r <= dec_control_s;
      illegal_r <= dec_illegal_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == ST_HOLD);
  assign bus.select    = select_r;
  assign bus.control   = control_r;
  assign bus.illegal   = illegal_r;
  assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized bench for alu_dispatch: three instances with different latency
// and M-extension settings share one stimulus stream and one encoding table.
module tb_alu_dispatch;

  localparam int NDUT = 3;
  localparam int MUL_L [NDUT] = '{3, 3, 1};
  localparam int DIV_L [NDUT] = '{33, 33, 2};
  localparam bit EN_M  [NDUT] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_is_imm;
  logic       out_ready;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       ov  [NDUT];
  logic       ir  [NDUT];
  logic       ill [NDUT];
  logic       bz  [NDUT];
  logic [2:0] sel [NDUT];
  logic [1:0] ctl [NDUT];

  logic [2:0] cap_sel [NDUT];
  logic [1:0] cap_ctl [NDUT];
  logic       cap_ill [NDUT];
  int         cap_lat [NDUT];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    alu_dispatch_if bus_i ();
    assign bus_i.in_valid  = in_valid;
    assign bus_i.in_is_imm = in_is_imm;
    assign bus_i.funct3    = funct3;
    assign bus_i.funct7    = funct7;
    assign bus_i.out_ready = out_ready;
    assign ov[g]  = bus_i.out_valid;
    assign ir[g]  = bus_i.in_ready;
    assign ill[g] = bus_i.illegal;
    assign sel[g] = bus_i.select;
    assign ctl[g] = bus_i.control;
    alu_dispatch #(
      .MUL_LATENCY (MUL_L[g]),
      .DIV_LATENCY (DIV_L[g]),
      .ENABLE_M    (EN_M[g])
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus_i),
      .busy  (bz[g])
    );
  end

  // Legal instruction list: kind 0 = single cycle, 1 = mul, 2 = div.
  typedef struct {
    bit       imm;
    bit [2:0] f3;
    bit [6:0] f7;
    bit       f7_care;
    bit [2:0] sel;
    bit [1:0] ctl;
    int       kind;
  } enc_t;
  enc_t tbl [$];

  function automatic void add(bit imm, bit [2:0] f3, bit [6:0] f7, bit care,
                              bit [2:0] s, bit [1:0] c, int kind);
    enc_t e;
    e.imm = imm; e.f3 = f3; e.f7 = f7; e.f7_care = care;
    e.sel = s; e.ctl = c; e.kind = kind;
    tbl.push_back(e);
  endfunction

  function automatic void build_table();
    bit [2:0] f;
    add(1'b0, 3'b000, 7'h00, 1'b1, 3'd0, 2'd0, 0);   // add
    add(1'b0, 3'b000, 7'h20, 1'b1, 3'd0, 2'd1, 0);   // sub
    add(1'b0, 3'b010, 7'h00, 1'b1, 3'd0, 2'd2, 0);   // slt
    add(1'b0, 3'b011, 7'h00, 1'b1, 3'd0, 2'd3, 0);   // sltu
    add(1'b0, 3'b001, 7'h00, 1'b1, 3'd3, 2'd0, 0);   // sll
    add(1'b0, 3'b101, 7'h00, 1'b1, 3'd4, 2'd0, 0);   // srl
    add(1'b0, 3'b101, 7'h20, 1'b1, 3'd4, 2'd1, 0);   // sra
    add(1'b0, 3'b100, 7'h00, 1'b1, 3'd5, 2'd0, 0);   // xor
    add(1'b0, 3'b110, 7'h00, 1'b1, 3'd6, 2'd0, 0);   // or
    add(1'b0, 3'b111, 7'h00, 1'b1, 3'd7, 2'd0, 0);   // and
    for (int i = 0; i < 8; i++) begin
      f = 3'(i);
      add(1'b0, f, 7'h01, 1'b1, (i < 4) ? 3'd1 : 3'd2, f[1:0], (i < 4) ? 1 : 2);
    end
    add(1'b1, 3'b000, 7'h00, 1'b0, 3'd0, 2'd0, 0);   // addi
    add(1'b1, 3'b010, 7'h00, 1'b0, 3'd0, 2'd2, 0);   // slti
    add(1'b1, 3'b011, 7'h00, 1'b0, 3'd0, 2'd3, 0);   // sltiu
    add(1'b1, 3'b100, 7'h00, 1'b0, 3'd5, 2'd0, 0);   // xori
    add(1'b1, 3'b110, 7'h00, 1'b0, 3'd6, 2'd0, 0);   // ori
    add(1'b1, 3'b111, 7'h00, 1'b0, 3'd7, 2'd0, 0);   // andi
    add(1'b1, 3'b001, 7'h00, 1'b1, 3'd3, 2'd0, 0);   // slli
    add(1'b1, 3'b101, 7'h00, 1'b1, 3'd4, 2'd0, 0);   // srli
    add(1'b1, 3'b101, 7'h20, 1'b1, 3'd4, 2'd1, 0);   // srai
  endfunction

  function automatic void ref_op(input int g, input bit imm, input bit [2:0] f3,
                                 input bit [6:0] f7, output bit [2:0] s,
                                 output bit [1:0] c, output bit il, output int lat);
    s = 3'd0; c = 2'd0; il = 1'b1; lat = 1;
    foreach (tbl[i]) begin
      if (tbl[i].imm == imm && tbl[i].f3 == f3 && (!tbl[i].f7_care || tbl[i].f7 == f7)) begin
        if (tbl[i].kind == 0 || EN_M[g]) begin
          s = tbl[i].sel; c = tbl[i].ctl; il = 1'b0;
          lat = (tbl[i].kind == 1) ? MUL_L[g] : (tbl[i].kind == 2) ? DIV_L[g] : 1;
        end
      end
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    out_ready = 1'b1;
    while ((bz[0] || bz[1] || bz[2]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_timeout: busy still %0d%0d%0d after %0d cycles, required 000",
               bz[0], bz[1], bz[2], n);
    end
  endtask

  // Issue one op to all instances and check latency, code and in_ready.
  task automatic run_op(input bit imm, input bit [2:0] f3, input bit [6:0] f7);
    bit [2:0] es; bit [1:0] ec; bit ei; int el;
    bit seen [NDUT];
    bit rdy_bad [NDUT];
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; in_is_imm = imm; funct3 = f3; funct7 = f7; out_ready = 1'b1;
    for (int g = 0; g < NDUT; g++) begin seen[g] = 1'b0; rdy_bad[g] = 1'b0; cap_lat[g] = 0; end
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
        if (!seen[g]) begin
          if (ov[g]) begin
            seen[g] = 1'b1; cap_lat[g] = cyc;
            cap_sel[g] = sel[g]; cap_ctl[g] = ctl[g]; cap_ill[g] = ill[g];
          end else if (ir[g]) begin
            rdy_bad[g] = 1'b1;
          end
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      ref_op(g, imm, f3, f7, es, ec, ei, el);
      checks++;
      if (cap_lat[g] !== el) begin
        errors++;
        $display("FAIL latency dut%0d imm=%0d f3=%b f7=%b: got %0d required %0d",
                 g, imm, f3, f7, cap_lat[g], el);
      end
      checks++;
      if ({cap_sel[g], cap_ctl[g], cap_ill[g]} !== {es, ec, ei}) begin
        errors++;
        $display("FAIL code dut%0d imm=%0d f3=%b f7=%b: got %b/%b ill=%b required %b/%b ill=%b",
                 g, imm, f3, f7, cap_sel[g], cap_ctl[g], cap_ill[g], es, ec, ei);
      end
      checks++;
      if (rdy_bad[g] !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_wait dut%0d f3=%b f7=%b: got in_ready 1 required 0", g, f3, f7);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_imm = 1'b0;
    funct3 = 3'd0; funct7 = 7'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({ov[g], ir[g], sel[g], ctl[g], ill[g], bz[g]} !== 9'b0_1_000_00_0_0) begin
        errors++;
        $display("FAIL reset_values dut%0d: got %b required 010000000", g,
                 {ov[g], ir[g], sel[g], ctl[g], ill[g], bz[g]});
      end
    end
  endtask

  task automatic test_sub();
    run_op(1'b0, 3'b000, 7'b0100000);
    checks++;
    if ({cap_sel[0], cap_ctl[0], cap_lat[0]} !== {3'b000, 2'b01, 32'd1}) begin
      errors++;
      $display("FAIL sub: got %b/%b lat %0d required 000/01 lat 1", cap_sel[0], cap_ctl[0], cap_lat[0]);
    end
    checks++;
    if (bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL sub_busy: got %b required 0", bz[0]);
    end
  endtask

  task automatic test_mulhu();
    run_op(1'b0, 3'b011, 7'b0000001);
    checks++;
    if ({cap_sel[0], cap_ctl[0], cap_lat[0]} !== {3'b001, 2'b11, 32'd3}) begin
      errors++;
      $display("FAIL mulhu: got %b/%b lat %0d required 001/11 lat 3", cap_sel[0], cap_ctl[0], cap_lat[0]);
    end
    checks++;
    if ({cap_ill[1], cap_sel[1], cap_lat[1]} !== {1'b1, 3'b000, 32'd1}) begin
      errors++;
      $display("FAIL mul_no_m: got ill=%b sel=%b lat %0d required ill=1 sel=000 lat 1",
               cap_ill[1], cap_sel[1], cap_lat[1]);
    end
  endtask

  task automatic test_imm();
    run_op(1'b1, 3'b101, 7'b0100000);
    checks++;
    if ({cap_sel[0], cap_ctl[0], cap_ill[0]} !== {3'b100, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL srai: got %b/%b ill=%b required 100/01 ill=0", cap_sel[0], cap_ctl[0], cap_ill[0]);
    end
    run_op(1'b1, 3'b000, 7'b0100000);
    checks++;
    if ({cap_sel[0], cap_ctl[0], cap_ill[0]} !== {3'b000, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL addi_f7: got %b/%b ill=%b required 000/00 ill=0", cap_sel[0], cap_ctl[0], cap_ill[0]);
    end
    run_op(1'b1, 3'b101, 7'b0000001);
    checks++;
    if ({cap_sel[0], cap_ctl[0], cap_ill[0]} !== {3'b000, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL imm_illegal: got %b/%b ill=%b required 000/00 ill=1", cap_sel[0], cap_ctl[0], cap_ill[0]);
    end
  endtask

  task automatic test_random();
    bit [6:0] f7;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      run_op(1'($urandom), 3'($urandom), f7);
    end
  endtask

  task automatic test_stall();
    int n;
    wait_idle();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_is_imm = 1'b0; funct3 = 3'b100; funct7 = 7'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!ov[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL div_latency: got %0d required 33", n);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; funct3 = 3'b111; funct7 = 7'h00;
      #1;
      checks++;
      if ({ov[0], sel[0], ctl[0], ill[0], ir[0]} !== {1'b1, 3'b010, 2'b00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_frozen cycle %0d: got %b required 1010000", k,
                 {ov[0], sel[0], ctl[0], ill[0], ir[0]});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL drain_ready: got %b required 1", ir[0]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({ov[0], sel[0], ctl[0], ill[0]} !== {1'b1, 3'b111, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back_and: got %b required 1111000", {ov[0], sel[0], ctl[0], ill[0]});
    end
    @(negedge clk);
    checks++;
    if (bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL after_drain_busy: got %b required 0", bz[0]);
    end
  endtask

  task automatic test_flush();
    bit late;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; in_is_imm = 1'b0; funct3 = 3'b100; funct7 = 7'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if ({bz[0], ov[0]} !== 2'b10) begin
      errors++;
      $display("FAIL wait10_state: got busy/valid %b required 10", {bz[0], ov[0]});
    end
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'b111; funct7 = 7'h00;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (ir[g] !== 1'b0) begin
        errors++;
        $display("FAIL flush_ready dut%0d: got %b required 0", g, ir[g]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({bz[g], ov[g]} !== 2'b00) begin
        errors++;
        $display("FAIL flush_idle dut%0d: got busy/valid %b required 00", g, {bz[g], ov[g]});
      end
    end
    late = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) late = 1'b1;
    end
    checks++;
    if (late !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_output: got out_valid 1 required 0");
    end
  endtask

  task automatic test_async_reset();
    bit late;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; in_is_imm = 1'b0; funct3 = 3'b101; funct7 = 7'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ov[0], ir[0], sel[0], ctl[0], ill[0], bz[0]} !== 9'b0_1_000_00_0_0) begin
      errors++;
      $display("FAIL async_reset: got %b required 010000000",
               {ov[0], ir[0], sel[0], ctl[0], ill[0], bz[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    late = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0] || bz[0]) late = 1'b1;
    end
    checks++;
    if (late !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: got activity after reset required none");
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_sub();
    test_mulhu();
    test_imm();
    test_random();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
